// File: rtl/iddr_align_ctrl.sv
// Word-alignment controller for the 4-lane IDDR capture block.
// Optional error counter enabled by IDDR_ALIGN_ERRCNT_EN.
module iddr_align_ctrl #(
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 'hB1,
  parameter int                MATCH_CNT = 4,
  parameter int                SETTLE    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    q_in,
  input  logic                          align_start,
  output logic [4*WORD_W-1:0]           word_out,
  output logic                          word_vld,
  output logic                          busy,
  output logic                          locked,
  output logic                          fail,
  output logic [1:0]                    fail_lane,
`ifdef IDDR_ALIGN_ERRCNT_EN
  output logic [15:0]                   err_cnt,
`endif
  output logic [4*$clog2(WORD_W)-1:0]   slip
);

  localparam int SW = $clog2(WORD_W);
  localparam int HW = 2 * WORD_W;
  localparam int PW = $clog2(WORD_W / 2);
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int TW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_SETTLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t            state, state_nx;
  logic [HW-1:0]     hist [4];
  logic [PW-1:0]     phase;
  logic              strobe;
  logic [WORD_W-1:0] lane_word [4];
  logic [WORD_W-1:0] cur_word;
  logic [SW-1:0]     cur_slip;
  logic [1:0]        lane_idx, lane_nx;
  logic [MW-1:0]     match_cnt, match_nx;
  logic [TW-1:0]     settle_cnt, settle_nx;
  logic [4*SW-1:0]   slip_nx;
  logic [1:0]        fail_lane_nx;

  assign strobe = (phase == PW'(WORD_W / 2 - 1));

  // Select each lane's word window and the word of the lane under search
  always_comb begin
    cur_word = '0;
    cur_slip = '0;
    for (int i = 0; i < 4; i++) begin
      lane_word[i] = WORD_W'(hist[i] >> slip[i*SW +: SW]);
      if (lane_idx == 2'(i)) begin
        cur_word = lane_word[i];
        cur_slip = slip[i*SW +: SW];
      end
    end
  end

  // Free-running deserializer: history shift, phase count, word register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      word_out <= '0;
      word_vld <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      phase    <= strobe ? '0 : phase + 1'b1;
      word_vld <= strobe;
      for (int i = 0; i < 4; i++) begin
        hist[i] <= {hist[i][HW-3:0], q_in[i], q_in[i+4]};
        if (strobe) word_out[i*WORD_W +: WORD_W] <= lane_word[i];
      end
    end
  end

  // Alignment FSM state and search bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lane_idx   <= '0;
      match_cnt  <= '0;
      settle_cnt <= '0;
      slip       <= '0;
      fail_lane  <= '0;
    end else begin
      state      <= state_nx;
      lane_idx   <= lane_nx;
      match_cnt  <= match_nx;
      settle_cnt <= settle_nx;
      slip       <= slip_nx;
      fail_lane  <= fail_lane_nx;
    end
  end

  // Next-state logic; a start pulse overrides any strobe decision
  always_comb begin
    state_nx     = state;
    lane_nx      = lane_idx;
    match_nx     = match_cnt;
    settle_nx    = settle_cnt;
    slip_nx      = slip;
    fail_lane_nx = fail_lane;
    if (align_start) begin
      state_nx     = S_SEARCH;
      lane_nx      = '0;
      match_nx     = '0;
      settle_nx    = '0;
      slip_nx      = '0;
      fail_lane_nx = '0;
    end else begin
      unique case (state)
        S_SEARCH: begin
          if (strobe) begin
            if (cur_word == TRAIN_PAT) begin
              if (match_cnt == MW'(MATCH_CNT - 1)) begin
                match_nx = '0;
                if (lane_idx == 2'd3) state_nx = S_LOCKED;
                else lane_nx = lane_idx + 2'd1;
              end else begin
                match_nx = match_cnt + 1'b1;
              end
            end else if (cur_slip != SW'(WORD_W - 1)) begin
              for (int i = 0; i < 4; i++)
                if (lane_idx == 2'(i))
                  slip_nx[i*SW +: SW] = cur_slip + 1'b1;
              match_nx  = '0;
              settle_nx = '0;
              state_nx  = S_SETTLE;
            end else begin
              fail_lane_nx = lane_idx;
              state_nx     = S_FAIL;
            end
          end
        end
        S_SETTLE: begin
          if (strobe) begin
            if (settle_cnt == TW'(SETTLE - 1)) begin
              settle_nx = '0;
              state_nx  = S_SEARCH;
            end else begin
              settle_nx = settle_cnt + 1'b1;
            end
          end
        end
        S_IDLE, S_LOCKED, S_FAIL: ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_SEARCH) || (state == S_SETTLE);
  assign locked = (state == S_LOCKED);
  assign fail   = (state == S_FAIL);

`ifdef IDDR_ALIGN_ERRCNT_EN
  logic any_err;

  always_comb begin
    any_err = 1'b0;
    for (int i = 0; i < 4; i++)
      if (lane_word[i] != TRAIN_PAT) any_err = 1'b1;
  end

  // Saturating count of corrupted words seen while locked
  always_ff @(posedge clk) begin
    if (rst || align_start) begin
      err_cnt <= '0;
    end else if (locked && strobe && any_err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  // Error monitoring is absent in this build.
`endif

endmodule

// File: tb/tb_iddr_align_ctrl.sv
// Directed self-checking bench for iddr_align_ctrl.
// Lane streams are generated from a bit counter restarted by rst.
module tb_iddr_align_ctrl;

  localparam logic [7:0] PAT = 8'hB1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        align_start = 1'b0;
  logic [7:0]  q_in = '0;
  logic [31:0] word_out;
  logic        word_vld, busy, locked, fail;
  logic [1:0]  fail_lane;
  logic [11:0] slip;
`ifdef IDDR_ALIGN_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  iddr_align_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .q_in        (q_in),
    .align_start (align_start),
    .word_out    (word_out),
    .word_vld    (word_vld),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .fail_lane   (fail_lane),
`ifdef IDDR_ALIGN_ERRCNT_EN
    .err_cnt     (err_cnt),
`endif
    .slip        (slip)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int g = 0;
  int off [4] = '{0, 0, 0, 0};
  bit stuck [4] = '{0, 0, 0, 0};
  bit flip3 = 1'b0;

  typedef struct packed {
    logic [3:0][2:0] off;
    logic [3:0]      stuck;
    logic            lk;
    logic            fl;
    logic [1:0]      ln;
    logic [11:0]     sl;
  } vec_t;

  vec_t vecs [6];

  // Stream bit g of a lane whose true word boundary sits o bits away
  // from the controller's slip-0 window.
  function automatic logic gen(int gg, int o);
    logic [7:0] p;
    p = PAT;
    return p[7 - ((gg + 2 + o) & 7)];
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      q_in[i]   = stuck[i] ? 1'b0 : gen(g, off[i]);
      q_in[i+4] = stuck[i] ? 1'b0 : gen(g + 1, off[i]);
    end
    q_in[3] = q_in[3] ^ flip3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) g = 0;
    else g = g + 2;
    drive();
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      tick();
      k++;
    end
    check(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_vld(string nm);
    int k;
    k = 0;
    while (!word_vld && k < 10) begin
      tick();
      k++;
    end
    check(nm, {31'd0, word_vld}, 32'd1);
  endtask

  task automatic wait_slip1(string nm);
    int k;
    k = 0;
    while (slip[5:3] == 3'd0 && k < 500) begin
      tick();
      k++;
    end
    check(nm, {31'd0, slip[5:3] != 3'd0}, 32'd1);
  endtask

  function automatic vec_t mk(int o3, int o2, int o1, int o0,
                              logic [3:0] st, logic lk, logic fl,
                              logic [1:0] ln, logic [11:0] sl);
    vec_t v;
    v.off[3] = 3'(o3);
    v.off[2] = 3'(o2);
    v.off[1] = 3'(o1);
    v.off[0] = 3'(o0);
    v.stuck  = st;
    v.lk     = lk;
    v.fl     = fl;
    v.ln     = ln;
    v.sl     = sl;
    return v;
  endfunction

  task automatic set_lanes(int o3, int o2, int o1, int o0, logic [3:0] st);
    off[3] = o3;
    off[2] = o2;
    off[1] = o1;
    off[0] = o0;
    for (int i = 0; i < 4; i++) stuck[i] = st[i];
    drive();
  endtask

  initial begin
    int n;
    bit moved;
    logic pbusy;

    vecs[0] = mk(7, 5, 3, 0, 4'b0000, 1, 0, 2'd0, 12'hF58);
    vecs[1] = mk(0, 0, 0, 0, 4'b0000, 1, 0, 2'd0, 12'h000);
    vecs[2] = mk(4, 0, 2, 1, 4'b0100, 0, 1, 2'd2, 12'h1D1);
    vecs[3] = mk(2, 4, 1, 6, 4'b0000, 1, 0, 2'd0, 12'h50E);
    vecs[4] = mk(0, 0, 0, 0, 4'b0001, 0, 1, 2'd0, 12'h007);
    vecs[5] = mk(0, 2, 2, 2, 4'b1000, 0, 1, 2'd3, 12'hE92);

    drive();
    do_reset();
    check("rst_word_out", word_out, 32'd0);
    check("rst_outs", {26'd0, word_vld, busy, locked, fail, fail_lane},
          32'd0);
    check("rst_slip", {20'd0, slip}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_lanes(vecs[v].off[3], vecs[v].off[2], vecs[v].off[1],
                vecs[v].off[0], vecs[v].stuck);
      repeat (10) tick();
      pulse_start();
      check($sformatf("v%0d_busy_start", v), {31'd0, busy}, 32'd1);
      wait_done($sformatf("v%0d_done", v));
      check($sformatf("v%0d_locked", v), {31'd0, locked},
            {31'd0, vecs[v].lk});
      check($sformatf("v%0d_fail", v), {31'd0, fail},
            {31'd0, vecs[v].fl});
      check($sformatf("v%0d_fail_lane", v), {30'd0, fail_lane},
            {30'd0, vecs[v].ln});
      check($sformatf("v%0d_slip", v), {20'd0, slip},
            {20'd0, vecs[v].sl});
      if (vecs[v].lk) begin
        wait_vld($sformatf("v%0d_vld", v));
        check($sformatf("v%0d_word", v), word_out, 32'hB1B1B1B1);
      end
    end

    // Offset-0 lanes: exactly 16 strobes, no slip moves, busy/locked swap
    do_reset();
    set_lanes(0, 0, 0, 0, 4'b0000);
    repeat (10) tick();
    pulse_start();
    n = 0;
    moved = 1'b0;
    pbusy = busy;
    for (int k = 0; k < 200; k++) begin
      pbusy = busy;
      tick();
      if (word_vld) n++;
      if (slip != 12'd0) moved = 1'b1;
      if (locked) break;
    end
    check("z_locked", {31'd0, locked}, 32'd1);
    check("z_strobes", n, 32'd16);
    check("z_no_slip", {31'd0, moved}, 32'd0);
    check("z_busy_edge", {30'd0, pbusy, busy}, 32'd2);

    // Restart while lane 1 is being searched
    do_reset();
    set_lanes(7, 5, 3, 0, 4'b0000);
    repeat (10) tick();
    pulse_start();
    wait_slip1("ab_lane1");
    repeat (3) tick();
    pulse_start();
    check("ab_slip_clr", {20'd0, slip}, 32'd0);
    check("ab_state", {29'd0, busy, locked, fail}, 32'd4);
    wait_done("ab_done");
    check("ab_relock", {31'd0, locked}, 32'd1);
    check("ab_reslip", {20'd0, slip}, 32'hF58);

    // Reset while settling after a slip change
    do_reset();
    set_lanes(7, 5, 3, 0, 4'b0000);
    repeat (10) tick();
    pulse_start();
    wait_slip1("rs_settle");
    do_reset();
    check("rs_word_out", word_out, 32'd0);
    check("rs_outs", {26'd0, word_vld, busy, locked, fail, fail_lane},
          32'd0);
    check("rs_slip", {20'd0, slip}, 32'd0);
    // rst low during cycle 1; word_vld is expected in cycle 5
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rs_vld_c%0d", k + 1), {31'd0, word_vld},
            (k == 4) ? 32'd1 : 32'd0);
    end
    check("rs_idle", {29'd0, busy, locked, fail}, 32'd0);

`ifdef IDDR_ALIGN_ERRCNT_EN
    do_reset();
    set_lanes(7, 5, 3, 0, 4'b0000);
    repeat (10) tick();
    pulse_start();
    wait_done("ec_done");
    repeat (12) tick();
    check("ec_zero", {16'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      flip3 = 1'b1;
      tick();
      flip3 = 1'b0;
      repeat (3) tick();
    end
    repeat (20) tick();
    check("ec_three", {16'd0, err_cnt}, 32'd3);
    check("ec_locked", {31'd0, locked}, 32'd1);
    pulse_start();
    check("ec_clear", {16'd0, err_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iddr_align_ctrl.md
Name: iddr_align_ctrl

Overview:
- Word-alignment controller behind the 4-lane IDDR capture block.
- Consumes the 8-bit IDDR output (lanes 0-3 rising-edge bits on q[3:0], falling-edge bits on q[7:4]) and deserializes each lane into WORD_W-bit words.
- Sequences a per-lane bit-slip search against a training pattern, lane by lane, then reports lock and delivers aligned parallel words to downstream logic.

Parameters:
- WORD_W, 8, bits per lane word; even, >= 4.
- TRAIN_PAT, 8'hB1, training word; no rotation of it equals itself.
- MATCH_CNT, 4, consecutive matching words required to lock one lane.
- SETTLE, 2, word strobes discarded after each slip change.

Ports:
- clk  in  1  capture clock, same clock as the IDDR.
- rst  in  1  synchronous, active-high reset.
- q_in  in  8  IDDR output; q_in[i] = lane i rise bit, q_in[i+4] = lane i fall bit.
- align_start  in  1  one-cycle pulse; (re)starts alignment from lane 0.
- word_out  out  4*WORD_W  lane i word on bits [i*WORD_W +: WORD_W]; MSB is the oldest bit.
- word_vld  out  1  one-cycle strobe per word.
- busy  out  1  alignment in progress.
- locked  out  1  all four lanes aligned.
- fail  out  1  a lane exhausted all slip offsets.
- fail_lane  out  2  index of the failing lane.
- slip  out  4*$clog2(WORD_W)  current slip offset per lane.

Behaviour:
- Reset: all outputs 0, all slips 0, phase counter 0, FSM in IDLE.
- Deserializer (free-running, independent of the FSM):
  - Each cycle, each lane shifts in rise then fall (the rise bit is older) into a 2*WORD_W history register.
  - A phase counter runs 0..WORD_W/2-1. The internal word strobe fires when the phase equals WORD_W/2-1.
  - The extracted lane word is the WORD_W-bit window at offset slip[i] from the newest bit.
  - word_out and word_vld are registered: valid 1 cycle after the internal strobe. word_vld is therefore high 1 of every WORD_W/2 cycles, regardless of lock state.
- FSM states: IDLE, SEARCH, SETTLE, LOCKED, FAIL.
  - IDLE: on align_start → SEARCH. Clear lane_idx, all slips, match_cnt, locked, fail. busy = 1.
  - SEARCH, evaluated on each internal strobe for lane lane_idx:
    - word == TRAIN_PAT: match_cnt++. When match_cnt reaches MATCH_CNT, lane lane_idx is done: clear match_cnt. If lane_idx == 3 → LOCKED, else lane_idx++ and stay in SEARCH.
    - Mismatch with slip < WORD_W-1: slip++, match_cnt = 0, → SETTLE.
    - Mismatch with slip == WORD_W-1: → FAIL, fail_lane = lane_idx.
  - SETTLE: counts SETTLE strobes, then → SEARCH.
  - LOCKED: locked = 1, busy = 0. Slips are held.
  - FAIL: fail = 1, busy = 0. Slips are held.
  - LOCKED and FAIL are left only by align_start or rst.
- A lane that has already locked keeps its slip while later lanes are searched.
- align_start in any state, including mid-search: same action as from IDLE on the next cycle; takes priority over a simultaneous strobe.
- rst mid-operation: immediate return to reset values; the phase counter restarts at 0.
- Worst-case time to lock: 4 * WORD_W * (MATCH_CNT + SETTLE) strobes.

Optional Feature:
- Macro: IDDR_ALIGN_ERRCNT_EN.
- Defined:
  - Adds output err_cnt (16 bits).
  - While in LOCKED, each strobe where any lane word != TRAIN_PAT increments err_cnt, saturating at 16'hFFFF.
  - err_cnt is cleared by rst or align_start.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Lanes 0-3 driven with the repeating 0xB1 stream at bit offsets 0,3,5,7; pulse align_start → locked = 1, slip = {7,5,3,0} (lane3..lane0), fail = 0, word_out = 32'hB1B1B1B1 on word_vld.
- All lanes aligned at offset 0 → lock after exactly 16 strobes with no slip changes; busy falls in the cycle that locked rises.
- Lane 2 stuck at 0 → lanes 0 and 1 lock; lane 2 sweeps slip 0..7 → fail = 1, fail_lane = 2, locked = 0.
- align_start pulsed during lane 1 search → slips return to 0, lane_idx = 0, and a full relock follows.
- rst asserted mid-SETTLE → next cycle all outputs 0 and FSM in IDLE; word_vld first pulses 5 cycles after rst is released (WORD_W = 8).
- With IDDR_ALIGN_ERRCNT_EN: after lock, flip one bit on lane 3 for 3 words → err_cnt = 3, locked stays 1.
